// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and round-robin pick.
// Latency: rr_pick is purely combinational.
// Backpressure: none here; the arbiter FSM owns all flow control.
package sdram_arb_pkg;

  localparam int MAX_PORT = 4;  // widest supported requester count
  localparam int GW       = 2;  // grant index width covering MAX_PORT

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_HOLD
  } arb_state_t;

  typedef struct packed {
    logic          vld;
    logic [GW-1:0] idx;
  } rr_pick_t;

  // First pending port found searching upward from last_grant+1, wrapping at nport.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORT-1:0] pending,
                                       input logic [GW-1:0]       last_grant,
                                       input int                  nport);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 1; k <= MAX_PORT; k++) begin
      j = (int'(last_grant) + k) % nport;
      if (k <= nport && !r.vld && pending[j]) begin
        r.vld = 1'b1;
        r.idx = GW'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the per-requester toggle ports and the single downstream SDRAM port.
// Latency: wires only.
// Backpressure: toggle handshake; a request stays pending while req != ack.
// slave  : arbiter side (consumes p_* requests, drives mem_* and acks)
// master : environment side (requesters plus the SDRAM controller)
interface sdram_port_arbiter_if #(
  parameter int NPORT = 3,
  parameter int AW    = 22
);
  logic [NPORT-1:0]    p_req;
  logic [NPORT-1:0]    p_ack;
  logic [NPORT-1:0]    p_lock;
  logic [NPORT*AW-1:0] p_addr;
  logic [NPORT-1:0]    p_we;
  logic [NPORT*2-1:0]  p_ds;
  logic [NPORT*16-1:0] p_din;
  logic [NPORT*16-1:0] p_dout;
  logic                mem_req;
  logic                mem_req_ack;
  logic [AW-1:0]       mem_addr;
  logic                mem_we;
  logic [1:0]          mem_ds;
  logic [15:0]         mem_din;
  logic [15:0]         mem_dout;

  modport slave (
    input  p_req, p_lock, p_addr, p_we, p_ds, p_din, mem_req_ack, mem_dout,
    output p_ack, p_dout, mem_req, mem_addr, mem_we, mem_ds, mem_din
  );

  modport master (
    output p_req, p_lock, p_addr, p_we, p_ds, p_din, mem_req_ack, mem_dout,
    input  p_ack, p_dout, mem_req, mem_addr, mem_we, mem_ds, mem_din
  );
endinterface

// File: rtl/sdram_rr_picker.sv
// Round-robin selector over NPORT pending bits, starting after last_grant.
// Latency: combinational.
// Backpressure: none; pick_vld simply reports whether anyone is pending.
// Ports: pending[NPORT] in, last_grant in, pick_vld/pick_idx out.
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NPORT = 3
) (
  input  logic [NPORT-1:0] pending,
  input  logic [GW-1:0]    last_grant,
  output logic             pick_vld,
  output logic [GW-1:0]    pick_idx
);

  logic [MAX_PORT-1:0] pend_w;
  rr_pick_t            pick;

  always_comb begin
    pend_w              = '0;
    pend_w[NPORT-1:0]   = pending;
    pick                = rr_pick(pend_w, last_grant, NPORT);
  end

  assign pick_vld = pick.vld;
  assign pick_idx = pick.idx;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one toggle-handshake SDRAM controller port among NPORT requesters (round-robin + lock).
// Latency: pending seen in IDLE -> mem_req toggles next cycle; downstream ack -> p_ack/p_dout next cycle.
// Backpressure: single outstanding downstream access; other requesters stay pending until granted.
// Ports: clk, reset (sync, active-high), bus (slave modport: p_* requester side, mem_* controller side).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORT        = 3,
  parameter int AW           = 22,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 2);

  arb_state_t       state, state_nxt;
  logic [GW-1:0]    grant, last_grant;
  logic [CW-1:0]    lock_cnt, lock_cnt_nxt;
  logic [NPORT-1:0] pending;
  logic             pick_vld;
  logic [GW-1:0]    pick_idx;
  logic             issue, complete;
  logic [GW-1:0]    issue_port;

  assign pending = bus.p_req ^ bus.p_ack;

  sdram_rr_picker #(.NPORT(NPORT)) u_picker (
    .pending    (pending),
    .last_grant (last_grant),
    .pick_vld   (pick_vld),
    .pick_idx   (pick_idx)
  );

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    issue        = 1'b0;
    issue_port   = grant;
    complete     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          issue      = 1'b1;
          issue_port = pick_idx;
          state_nxt  = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.mem_req_ack == bus.mem_req) begin
          complete     = 1'b1;
          lock_cnt_nxt = '0;
          state_nxt    = bus.p_lock[grant] ? ARB_HOLD : ARB_IDLE;
        end
      end
      ARB_HOLD: begin
        // The owner's request wins even in the cycle the lock would otherwise expire.
        if (pending[grant]) begin
          issue        = 1'b1;
          lock_cnt_nxt = '0;
          state_nxt    = ARB_WAIT;
        end else if (!bus.p_lock[grant] || lock_cnt == CW'(LOCK_TIMEOUT)) begin
          lock_cnt_nxt = '0;
          state_nxt    = ARB_IDLE;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      last_grant   <= GW'(NPORT - 1);
      lock_cnt     <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_ds   <= '0;
      bus.mem_din  <= '0;
      bus.p_ack    <= '0;
      bus.p_dout   <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (issue) begin
        bus.mem_addr <= bus.p_addr[issue_port*AW +: AW];
        bus.mem_we   <= bus.p_we[issue_port];
        bus.mem_ds   <= bus.p_ds[issue_port*2 +: 2];
        bus.mem_din  <= bus.p_din[issue_port*16 +: 16];
        bus.mem_req  <= ~bus.mem_req;
        grant        <= issue_port;
        last_grant   <= issue_port;
      end
      if (complete) begin
        // Writes capture too; their returned data is don't-care for the requester.
        bus.p_dout[grant*16 +: 16] <= bus.mem_dout;
        bus.p_ack[grant]           <= ~bus.p_ack[grant];
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed and randomized bench for sdram_port_arbiter with a latency-configurable controller model.
// Latency: n/a.
// Backpressure: controller model acks each downstream request after a programmable delay.
module tb_sdram_port_arbiter;

  localparam int NPORT = 3;
  localparam int AW    = 22;
  localparam int LT    = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NPORT(NPORT), .AW(AW)) bus ();

  sdram_port_arbiter #(.NPORT(NPORT), .AW(AW), .LOCK_TIMEOUT(LT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [1:0]    ds;
    logic [15:0]   din;
    int            cyc;
  } txn_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ctrl_lat = 3;
  bit   ctrl_rand = 1'b0;
  bit   rr_check  = 1'b0;
  int   model_last = NPORT - 1;
  int   ack_cyc = 0;
  txn_t log_q[$];
  logic [NPORT-1:0] pend_snap = '0;
  logic [AW-1:0]    rq_addr [NPORT];
  logic             rq_we   [NPORT];
  logic [1:0]       rq_ds   [NPORT];
  logic [15:0]      rq_din  [NPORT];

  always @(posedge clk) cyc <= cyc + 1;

  // Read data the controller model returns for any address.
  function automatic logic [15:0] exp_rdata(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h9DAA;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int p, input logic [AW-1:0] a, input logic we,
                       input logic [1:0] ds, input logic [15:0] din, input logic lock);
    bus.p_addr[p*AW +: AW] = a;
    bus.p_we[p]            = we;
    bus.p_ds[p*2 +: 2]     = ds;
    bus.p_din[p*16 +: 16]  = din;
    bus.p_lock[p]          = lock;
    rq_addr[p] = a;
    rq_we[p]   = we;
    rq_ds[p]   = ds;
    rq_din[p]  = din;
    bus.p_req[p] = ~bus.p_req[p];
  endtask

  task automatic wait_done(input int p, input int budget, output int done_cyc);
    bit ok;
    ok = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.p_ack[p] === bus.p_req[p]) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
      step(1);
    end
    check($sformatf("done_port%0d", p), 32'(ok), 1);
  endtask

  task automatic expect_txn(input string tag, input logic [AW-1:0] a, input logic we, output txn_t t);
    t.addr = '0; t.we = 1'b0; t.ds = '0; t.din = '0; t.cyc = 0;
    check({tag, "_seen"}, 32'(log_q.size() > 0), 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      check({tag, "_addr"}, 32'(t.addr), 32'(a));
      check({tag, "_we"}, 32'(t.we), 32'(we));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.p_req  = '0;
    bus.p_lock = '0;
    step(2);
    reset = 1'b0;
    log_q.delete();
    step(1);
  endtask

  // Pending view the DUT samples at the next rising edge.
  initial forever begin
    @(negedge clk);
    pend_snap = bus.p_req ^ bus.p_ack;
  end

  // SDRAM controller model: one access at a time, ack after a delay, logs every issue.
  initial begin
    txn_t t;
    int   cnt;
    int   e;
    bit   busy;
    bit   unstable;
    bus.mem_req_ack = 1'b0;
    bus.mem_dout    = '0;
    busy = 1'b0; unstable = 1'b0; cnt = 0;
    t.addr = '0; t.we = 1'b0; t.ds = '0; t.din = '0; t.cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        bus.mem_req_ack = 1'b0;
        busy = 1'b0;
      end else if (busy) begin
        if (bus.mem_addr !== t.addr || bus.mem_we !== t.we || bus.mem_ds !== t.ds ||
            bus.mem_din !== t.din || bus.mem_req === bus.mem_req_ack)
          unstable = 1'b1;
        cnt--;
        if (cnt <= 0) begin
          check("mem_stable", 32'(unstable), 0);
          bus.mem_dout    = t.we ? 16'hDEAD : exp_rdata(t.addr);
          bus.mem_req_ack = bus.mem_req;
          ack_cyc = cyc;
          busy = 1'b0;
        end
      end else if (bus.mem_req !== bus.mem_req_ack) begin
        t.addr = bus.mem_addr; t.we = bus.mem_we; t.ds = bus.mem_ds;
        t.din = bus.mem_din;   t.cyc = cyc;
        log_q.push_back(t);
        if (rr_check) begin
          // Expected winner: first pending port after the previous winner, wrapping.
          e = -1;
          for (int k = 1; k <= NPORT; k++)
            if (e < 0 && pend_snap[(model_last + k) % NPORT]) e = (model_last + k) % NPORT;
          check("rr_has_pending", 32'(e >= 0), 1);
          if (e >= 0) begin
            check("rr_addr", 32'(bus.mem_addr), 32'(rq_addr[e]));
            check("rr_we", 32'(bus.mem_we), 32'(rq_we[e]));
            if (rq_we[e]) begin
              check("rr_ds", 32'(bus.mem_ds), 32'(rq_ds[e]));
              check("rr_din", 32'(bus.mem_din), 32'(rq_din[e]));
            end
            model_last = e;
          end
        end
        busy = 1'b1;
        unstable = 1'b0;
        cnt = ctrl_rand ? int'($urandom_range(1, 6)) : ctrl_lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   rc, dc, h, served;
    logic [NPORT-1:0] outst;
    bus.p_req = '0; bus.p_lock = '0; bus.p_addr = '0;
    bus.p_we = '0;  bus.p_ds = '0;   bus.p_din = '0;
    for (int p = 0; p < NPORT; p++) begin
      rq_addr[p] = '0; rq_we[p] = 1'b0; rq_ds[p] = '0; rq_din[p] = '0;
    end
    reset = 1'b1;
    step(3);

    // Reset values
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_p_ack", 32'(bus.p_ack), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_ds", 32'(bus.mem_ds), 0);
    check("rst_mem_din", 32'(bus.mem_din), 0);
    check("rst_p_dout", 32'(bus.p_dout[31:0]), 0);
    check("rst_p_dout2", 32'(bus.p_dout[47:32]), 0);
    reset = 1'b0;
    step(1);

    // Single read on port 1, controller latency 5
    ctrl_lat = 5;
    issue(1, 22'h12345, 1'b0, 2'b11, 16'h0, 1'b0);
    rc = cyc;
    wait_done(1, 50, dc);
    expect_txn("rd", 22'h12345, 1'b0, t);
    check("rd_issue_lat", t.cyc - rc, 1);
    check("rd_ack_lat", dc - ack_cyc, 1);
    check("rd_p_ack1", 32'(bus.p_ack[1]), 1);
    check("rd_p_dout1", 32'(bus.p_dout[16 +: 16]), 32'hBEEF);

    // Simultaneous requests, two rounds: order 0,1,2 each time
    do_reset();
    ctrl_lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NPORT; p++)
        issue(p, AW'((p << 8) | r), 1'b0, 2'b11, 16'h0, 1'b0);
      for (int p = 0; p < NPORT; p++) wait_done(p, 80, dc);
      for (int p = 0; p < NPORT; p++)
        expect_txn($sformatf("sim_r%0d_p%0d", r, p), AW'((p << 8) | r), 1'b0, t);
    end

    // Lock atomicity: port 0's second halfword beats pending port 2
    do_reset();
    ctrl_lat = 3;
    issue(0, 22'h100, 1'b0, 2'b11, 16'h0, 1'b1);
    issue(2, 22'h300, 1'b0, 2'b11, 16'h0, 1'b0);
    wait_done(0, 50, dc);
    step(3);
    issue(0, 22'h101, 1'b0, 2'b11, 16'h0, 1'b0);
    wait_done(0, 50, dc);
    wait_done(2, 50, dc);
    expect_txn("lock_a", 22'h100, 1'b0, t);
    expect_txn("lock_b", 22'h101, 1'b0, t);
    expect_txn("lock_c", 22'h300, 1'b0, t);

    // Lock timeout: HOLD entered with p_ack; IDLE decision LT+1 cycles later, mem_req one stage after
    do_reset();
    issue(0, 22'h200, 1'b0, 2'b11, 16'h0, 1'b1);
    issue(2, 22'h302, 1'b0, 2'b11, 16'h0, 1'b0);
    wait_done(0, 50, h);
    wait_done(2, 80, dc);
    bus.p_lock = '0;
    expect_txn("lto_a", 22'h200, 1'b0, t);
    expect_txn("lto_b", 22'h302, 1'b0, t);
    check("lto_delay", t.cyc - h, LT + 2);

    // Write pass-through on port 2
    ctrl_lat = 4;
    issue(2, 22'h0ABCD, 1'b1, 2'b10, 16'hA55A, 1'b0);
    wait_done(2, 50, dc);
    expect_txn("wr", 22'h0ABCD, 1'b1, t);
    check("wr_ds", 32'(t.ds), 32'h2);
    check("wr_din", 32'(t.din), 32'hA55A);

    // Reset during WAIT, then a fresh request
    ctrl_lat = 20;
    issue(1, 22'h05555, 1'b0, 2'b11, 16'h0, 1'b0);
    step(4);
    reset = 1'b1;
    bus.p_req = '0;
    step(1);
    check("rstw_mem_req", 32'(bus.mem_req), 0);
    check("rstw_p_ack", 32'(bus.p_ack), 0);
    reset = 1'b0;
    log_q.delete();
    ctrl_lat = 3;
    step(1);
    issue(1, 22'h06666, 1'b0, 2'b11, 16'h0, 1'b0);
    wait_done(1, 50, dc);
    expect_txn("rstw_fresh", 22'h06666, 1'b0, t);
    check("rstw_dout", 32'(bus.p_dout[16 +: 16]), 32'(exp_rdata(22'h06666)));

    // Randomized traffic checked against the round-robin reference
    do_reset();
    model_last = NPORT - 1;
    rr_check = 1'b1;
    ctrl_rand = 1'b1;
    outst = '0;
    served = 0;
    for (int c = 0; c < 1400; c++) begin
      for (int p = 0; p < NPORT; p++) begin
        if (outst[p] && bus.p_ack[p] === bus.p_req[p]) begin
          if (!rq_we[p])
            check("rand_dout", 32'(bus.p_dout[p*16 +: 16]), 32'(exp_rdata(rq_addr[p])));
          outst[p] = 1'b0;
          served++;
        end else if (!outst[p] && $urandom_range(0, 2) == 0) begin
          issue(p, {2'(p), 20'($urandom)}, 1'($urandom), 2'($urandom_range(1, 3)),
                16'($urandom), 1'b0);
          outst[p] = 1'b1;
        end
      end
      step(1);
    end
    for (int c = 0; c < 200 && outst != '0; c++) begin
      for (int p = 0; p < NPORT; p++)
        if (outst[p] && bus.p_ack[p] === bus.p_req[p]) begin
          outst[p] = 1'b0;
          served++;
        end
      step(1);
    end
    check("rand_drained", 32'(outst), 0);
    check("rand_served", 32'(served >= 100), 1);
    rr_check = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
